// File: rtl/bip_control_pkg.sv
// Shared definitions for the BIP control unit: widths, opcodes, MUX_A select codes,
// FSM encoding and the instruction decoder used by bip_control.
package bip_control_pkg;

  localparam int LEN_INST   = 16;
  localparam int LEN_OPCODE = 5;
  localparam int LEN_ADDR   = 11;
  localparam int LEN_MUX_A  = 2;
  localparam int LEN_CNT    = 16;

  localparam logic [LEN_MUX_A-1:0] SELA_MEM = 2'b00;
  localparam logic [LEN_MUX_A-1:0] SELA_OPR = 2'b01;
  localparam logic [LEN_MUX_A-1:0] SELA_ALU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [LEN_OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [LEN_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [LEN_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [LEN_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [LEN_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [LEN_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [LEN_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [LEN_OPCODE-1:0] OP_SUBI = 5'b00111;

  typedef struct packed {
    logic [LEN_MUX_A-1:0] sel_a;
    logic                 sel_b;
    logic                 wr_acc;
    logic                 op;
    logic                 wr_ram;
    logic                 rd_ram;
  } ctrl_t;

  // Unknown opcodes fall through to all-zero controls, so SelA never reaches 2'b11.
  function automatic ctrl_t decode(input logic [LEN_OPCODE-1:0] opc);
    ctrl_t c;
    c = '0;
    case (opc)
      OP_STO:  c.wr_ram = 1'b1;
      OP_LD:   begin c.rd_ram = 1'b1; c.sel_a = SELA_MEM; c.wr_acc = 1'b1; end
      OP_LDI:  begin c.sel_a = SELA_OPR; c.wr_acc = 1'b1; end
      OP_ADD:  begin c.rd_ram = 1'b1; c.sel_a = SELA_ALU; c.wr_acc = 1'b1; end
      OP_ADDI: begin c.sel_b = 1'b1; c.sel_a = SELA_ALU; c.wr_acc = 1'b1; end
      OP_SUB:  begin c.rd_ram = 1'b1; c.op = 1'b1; c.sel_a = SELA_ALU; c.wr_acc = 1'b1; end
      OP_SUBI: begin c.sel_b = 1'b1; c.op = 1'b1; c.sel_a = SELA_ALU; c.wr_acc = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bip_control_if.sv
// Signal bundle between the BIP control unit (master) and program memory / datapath (slave).
interface bip_control_if;
  import bip_control_pkg::*;

  // start is a one-cycle pulse sampled only in IDLE; there is no back-pressure on this bus.
  logic                  start;
  logic [LEN_INST-1:0]   instruction;
  logic [LEN_ADDR-1:0]   pc;
  logic [LEN_ADDR-1:0]   operand;
  logic [LEN_MUX_A-1:0]  SelA;
  logic                  SelB;
  logic                  WrAcc;
  logic                  Op;
  logic                  WrRam;
  logic                  RdRam;
  logic                  halted;
  logic [LEN_CNT-1:0]    inst_count;
  state_t                state;

  modport master (
    input  start, instruction,
    output pc, operand, SelA, SelB, WrAcc, Op, WrRam, RdRam, halted, inst_count, state
  );

  modport slave (
    output start, instruction,
    input  pc, operand, SelA, SelB, WrAcc, Op, WrRam, RdRam, halted, inst_count, state
  );

endinterface

// File: rtl/bip_pc.sv
// Program counter: advances by one when enabled, wraps silently at the top of the address space.
module bip_pc
  import bip_control_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                en_i,
  output logic [LEN_ADDR-1:0] pc_o
);

  logic [LEN_ADDR-1:0] pc_q;
  logic [LEN_ADDR-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (en_i) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pc_q <= '0;
    else          pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/bip_control.sv
// BIP control unit: IDLE/RUN/HALT sequencer, program counter, executed-instruction counter
// and single-cycle instruction decode for the datapath.
module bip_control
  import bip_control_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  bip_control_if.master bus
);

  logic [LEN_OPCODE-1:0] opcode;
  state_t                state_q, state_d;
  logic [LEN_CNT-1:0]    cnt_q, cnt_d;
  logic                  pc_en;
  logic                  cnt_inc;
  ctrl_t                 ctrl;

  assign opcode = bus.instruction[LEN_INST-1:LEN_INST-LEN_OPCODE];

  always_comb begin
    state_d = state_q;
    pc_en   = 1'b0;
    cnt_inc = 1'b0;
    ctrl    = '0;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        ctrl    = decode(opcode);
        cnt_inc = 1'b1;
        // HLT is counted but leaves pc parked on its own address.
        if (opcode == OP_HLT) state_d = ST_HALT;
        else                  pc_en   = 1'b1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  bip_pc u_pc (
    .clk_i   (clk),
    .rst_n_i (reset),
    .en_i    (pc_en),
    .pc_o    (bus.pc)
  );

  assign bus.operand    = bus.instruction[LEN_ADDR-1:0];
  assign bus.SelA       = ctrl.sel_a;
  assign bus.SelB       = ctrl.sel_b;
  assign bus.WrAcc      = ctrl.wr_acc;
  assign bus.Op         = ctrl.op;
  assign bus.WrRam      = ctrl.wr_ram;
  assign bus.RdRam      = ctrl.rd_ram;
  assign bus.halted     = (state_q == ST_HALT);
  assign bus.inst_count = cnt_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: decode table, program run, halt, reset and pc wrap.
module tb_bip_control;
  import bip_control_pkg::*;

  typedef struct {
    logic [15:0] inst;
    logic [1:0]  sela;
    logic        selb, wracc, op, wrram, rdram;
  } dec_vec_t;

  typedef struct {
    logic [1:0] sela;
    logic       selb, wracc, op, wrram, rdram, halted;
  } prog_vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic use_prog;
  logic [15:0] instr_drv;
  logic [15:0] prog [0:2047];

  int checks = 0;
  int failures = 0;

  dec_vec_t  dec_tab [0:30];
  prog_vec_t prog_tab [0:6];
  logic [10:0] exp_q [$];

  bip_control_if bus ();

  bip_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb bus.instruction = use_prog ? prog[bus.pc] : instr_drv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_ctrl(input string name, input logic [1:0] sa, input logic sb,
                          input logic wa, input logic op, input logic wr, input logic rd);
    chk(name, {25'd0, bus.SelA, bus.SelB, bus.WrAcc, bus.Op, bus.WrRam, bus.RdRam},
        {25'd0, sa, sb, wa, op, wr, rd});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v;
    logic [10:0] exp_pc;
    logic [15:0] exp_cnt;
    logic        any_strobe;

    dec_tab[0] = '{16'h0805, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dec_tab[1] = '{16'h1123, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    dec_tab[2] = '{16'h1FFF, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    dec_tab[3] = '{16'h2001, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    dec_tab[4] = '{16'h2A55, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    dec_tab[5] = '{16'h3400, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    dec_tab[6] = '{16'h38AA, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 8; k < 32; k++) begin
      v = {k[4:0], 11'(k * 37)};
      dec_tab[k - 1] = '{v, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end

    prog_tab[0] = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    prog_tab[1] = '{2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    prog_tab[2] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    prog_tab[3] = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    prog_tab[4] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    prog_tab[5] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    prog_tab[6] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int a = 0; a < 2048; a++) prog[a] = 16'h4000;
    use_prog  = 1'b0;
    instr_drv = 16'h0000;
    bus.start = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_cnt", 32'(bus.inst_count), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk_ctrl("rst_ctrl", 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // IDLE hold with LDI 5 presented
    instr_drv = 16'h1805;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("idle_wracc%0d", c), 32'(bus.WrAcc), 0);
      chk($sformatf("idle_pc%0d", c), 32'(bus.pc), 0);
    end
    pulse_start();
    chk_ctrl("start_ldi_ctrl", 2'b01, 0, 1, 0, 0, 0);
    chk("start_ldi_operand", 32'(bus.operand), 5);
    chk("start_ldi_pc", 32'(bus.pc), 0);

    // Reach pc=5 then reset mid-instruction with a store strobe live
    repeat (5) @(negedge clk);
    instr_drv = 16'h0807;
    #1;
    chk("mid_pc", 32'(bus.pc), 5);
    chk("mid_cnt", 32'(bus.inst_count), 5);
    chk("mid_wrram", 32'(bus.WrRam), 1);
    reset = 1'b0;
    #1;
    chk("async_pc", 32'(bus.pc), 0);
    chk("async_cnt", 32'(bus.inst_count), 0);
    chk("async_halted", 32'(bus.halted), 0);
    chk_ctrl("async_ctrl", 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst_pc%0d", c), 32'(bus.pc), 0);
      chk($sformatf("post_rst_wrram%0d", c), 32'(bus.WrRam), 0);
    end

    // Program: LDI 3; ADDI 4; STO 7; SUB 7; HLT
    prog[0] = 16'h1803;
    prog[1] = 16'h2804;
    prog[2] = 16'h0807;
    prog[3] = 16'h3007;
    prog[4] = 16'h0000;
    use_prog = 1'b1;
    for (int p = 0; p < 7; p++) exp_q.push_back(11'(p < 4 ? p : 4));
    pulse_start();
    for (int p = 0; p < 7; p++) begin
      if (p > 0) begin
        @(negedge clk);
        #1;
      end
      chk($sformatf("prog_pc%0d", p), 32'(bus.pc), 32'(exp_q.pop_front()));
      chk_ctrl($sformatf("prog_ctrl%0d", p), prog_tab[p].sela, prog_tab[p].selb,
               prog_tab[p].wracc, prog_tab[p].op, prog_tab[p].wrram, prog_tab[p].rdram);
      chk($sformatf("prog_halted%0d", p), 32'(bus.halted), 32'(prog_tab[p].halted));
    end
    chk("prog_cnt", 32'(bus.inst_count), 5);

    // Halt is sticky: start pulse and an LDI opcode change nothing
    use_prog  = 1'b0;
    instr_drv = 16'h1805;
    pulse_start();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk_ctrl($sformatf("halt_ctrl%0d", c), 2'b00, 0, 0, 0, 0, 0);
      chk($sformatf("halt_pc%0d", c), 32'(bus.pc), 4);
      chk($sformatf("halt_halted%0d", c), 32'(bus.halted), 1);
      chk($sformatf("halt_cnt%0d", c), 32'(bus.inst_count), 5);
    end

    // Decode table, including every unused opcode
    do_reset();
    instr_drv = dec_tab[0].inst;
    pulse_start();
    exp_pc  = '0;
    exp_cnt = '0;
    for (int i = 0; i < 31; i++) begin
      if (i > 0) begin
        @(negedge clk);
        instr_drv = dec_tab[i].inst;
        #1;
      end
      v = dec_tab[i].inst;
      chk_ctrl($sformatf("dec_ctrl%0d", i), dec_tab[i].sela, dec_tab[i].selb,
               dec_tab[i].wracc, dec_tab[i].op, dec_tab[i].wrram, dec_tab[i].rdram);
      chk($sformatf("dec_sela11_%0d", i), 32'(bus.SelA == 2'b11), 0);
      chk($sformatf("dec_operand%0d", i), 32'(bus.operand), 32'(v[10:0]));
      chk($sformatf("dec_pc%0d", i), 32'(bus.pc), 32'(exp_pc));
      chk($sformatf("dec_cnt%0d", i), 32'(bus.inst_count), 32'(exp_cnt));
      exp_pc  = exp_pc + 1'b1;
      exp_cnt = exp_cnt + 1'b1;
    end

    // Wrap through the full address space on NOP words
    for (int a = 0; a < 2048; a++) prog[a] = 16'h4000;
    use_prog = 1'b1;
    do_reset();
    pulse_start();
    any_strobe = 1'b0;
    for (int c = 0; c < 2046; c++) begin
      @(negedge clk);
      #1;
      if ({bus.SelA, bus.SelB, bus.WrAcc, bus.Op, bus.WrRam, bus.RdRam} != '0) any_strobe = 1'b1;
    end
    chk("wrap_no_strobes", 32'(any_strobe), 0);
    chk("wrap_pc2046", 32'(bus.pc), 2046);
    @(negedge clk);
    #1;
    chk("wrap_pc2047", 32'(bus.pc), 2047);
    @(negedge clk);
    #1;
    chk("wrap_pc0", 32'(bus.pc), 0);
    chk("wrap_cnt", 32'(bus.inst_count), 2048);
    chk_ctrl("wrap_ctrl", 2'b00, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
